// File: rtl/register_file_multiport.sv
// Multi-read-port integer register file with post-reset sequential clear (block-RAM friendly).
// Optional same-cycle write-to-read forwarding when REGFILE_WRITE_BYPASS_EN is defined.
//
// state    | meaning
// ---------|----------------------------------------------------------
// ST_CLEAR | zeroing storage one register per cycle; reads forced to 0
// ST_RUN   | normal operation; combinational reads, registered writes

module register_file_multiport #(
   parameter int XLEN          = 32,
   parameter int REG_COUNT     = 32,
   parameter int READ_PORTS    = 2,
   parameter int ADDR_WIDTH    = $clog2(REG_COUNT),
   parameter int OBSERVE_INDEX = REG_COUNT - 1
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic [READ_PORTS*ADDR_WIDTH-1:0] readAddress,
   output logic [READ_PORTS*XLEN-1:0]       readData,
   input  logic [ADDR_WIDTH-1:0]            writeAddress,
   input  logic [XLEN-1:0]                  writeData,
   input  logic                             writeEnable,
   output logic                             ready,
   output logic [XLEN-1:0]                  observeOutput
);

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] LAST_INDEX = ADDR_WIDTH'(REG_COUNT - 1);

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   clear_index_q, clear_index_d;
   logic                    ready_q, ready_d;

   logic [XLEN-1:0]         mem_q [REG_COUNT];
   logic                    mem_we_d;
   logic [ADDR_WIDTH-1:0]   mem_waddr_d;
   logic [XLEN-1:0]         mem_wdata_d;

   // Register 0 and addresses past the end of a non-power-of-two file never hold data.
   function automatic logic addr_valid(input logic [ADDR_WIDTH-1:0] a);
      return (a != '0) && (32'(a) < 32'(REG_COUNT));
   endfunction

   always_comb begin
      state_d       = state_q;
      clear_index_d = clear_index_q;
      ready_d       = ready_q;
      mem_we_d      = 1'b0;
      mem_waddr_d   = writeAddress;
      mem_wdata_d   = writeData;

      case (state_q)
         ST_CLEAR: begin
            mem_we_d    = 1'b1;
            mem_waddr_d = clear_index_q;
            mem_wdata_d = '0;
            if (clear_index_q == LAST_INDEX) begin
               state_d = ST_RUN;
               ready_d = 1'b1;
            end else begin
               clear_index_d = clear_index_q + ADDR_WIDTH'(1);
            end
         end
         ST_RUN: begin
            if (writeEnable && addr_valid(writeAddress)) begin
               mem_we_d = 1'b1;
            end
         end
         default: begin
            state_d = ST_CLEAR;
         end
      endcase

      // Storage is left untouched while reset is held, including any write issued alongside it.
      if (reset) begin
         mem_we_d = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= ST_CLEAR;
         clear_index_q <= '0;
         ready_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         clear_index_q <= clear_index_d;
         ready_q       <= ready_d;
      end
   end

   // Single write port, no reset on the array so it maps onto block RAM.
   always_ff @(posedge clock) begin
      if (mem_we_d) begin
         mem_q[mem_waddr_d] <= mem_wdata_d;
      end
   end

   always_comb begin
      logic [ADDR_WIDTH-1:0] lane_addr;
      lane_addr = '0;
      readData  = '0;
      for (int p = 0; p < READ_PORTS; p++) begin
         lane_addr = readAddress[p*ADDR_WIDTH +: ADDR_WIDTH];
         if ((state_q == ST_RUN) && addr_valid(lane_addr)) begin
            readData[p*XLEN +: XLEN] = mem_q[lane_addr];
`ifdef REGFILE_WRITE_BYPASS_EN
            if (writeEnable && (lane_addr == writeAddress)) begin
               readData[p*XLEN +: XLEN] = writeData;
            end
`endif
         end
      end
   end

   generate
      if ((OBSERVE_INDEX > 0) && (OBSERVE_INDEX < REG_COUNT)) begin : g_observe
         assign observeOutput = (state_q == ST_RUN) ? mem_q[OBSERVE_INDEX] : '0;
      end else begin : g_observe_zero
         assign observeOutput = '0;
      end
   endgenerate

   assign ready = ready_q;

endmodule

// File: tb/tb_register_file_multiport.sv
// Self-checking bench: default build (32x32, 2 ports) and a 24x64, 3-port instance,
// constant vector table plus randomized traffic against an array-based reference model.

module tb_register_file_multiport;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic        a_reset, a_we, a_ready;
   logic [9:0]  a_raddr;
   logic [63:0] a_rdata;
   logic [4:0]  a_waddr;
   logic [31:0] a_wdata, a_obs;

   logic         b_reset, b_we, b_ready;
   logic [14:0]  b_raddr;
   logic [191:0] b_rdata;
   logic [4:0]   b_waddr;
   logic [63:0]  b_wdata, b_obs;

   register_file_multiport dut_a (
      .clock(clock), .reset(a_reset), .readAddress(a_raddr), .readData(a_rdata),
      .writeAddress(a_waddr), .writeData(a_wdata), .writeEnable(a_we),
      .ready(a_ready), .observeOutput(a_obs)
   );

   register_file_multiport #(.XLEN(64), .REG_COUNT(24), .READ_PORTS(3)) dut_b (
      .clock(clock), .reset(b_reset), .readAddress(b_raddr), .readData(b_rdata),
      .writeAddress(b_waddr), .writeData(b_wdata), .writeEnable(b_we),
      .ready(b_ready), .observeOutput(b_obs)
   );

   int tests = 0;
   int fails = 0;

   logic [31:0] ma [32];
   logic [63:0] mb [24];

   typedef struct {
      logic        we;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic [4:0]  r0;
      logic [4:0]  r1;
      logic [31:0] e0;
      logic [31:0] e1;
   } vec_t;

   vec_t vt [8];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic wait_ready(input int which, output int n);
      n = 0;
      while (((which == 0) ? a_ready : b_ready) !== 1'b1 && n < 100) begin
         tick();
         n++;
      end
   endtask

   function automatic logic [31:0] exp_a(input logic [4:0] ra, input logic we,
                                         input logic [4:0] wa, input logic [31:0] wd);
      if (ra == 5'd0) return 32'h0;
`ifdef REGFILE_WRITE_BYPASS_EN
      if (we && ra == wa) return wd;
`endif
      return ma[ra];
   endfunction

   function automatic logic [63:0] exp_b(input logic [4:0] ra, input logic we,
                                         input logic [4:0] wa, input logic [63:0] wd);
      if (ra == 5'd0 || ra >= 5'd24) return 64'h0;
`ifdef REGFILE_WRITE_BYPASS_EN
      if (we && ra == wa) return wd;
`endif
      return mb[ra];
   endfunction

   task automatic a_drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                          input logic [4:0] r0, input logic [4:0] r1);
      a_we = we; a_waddr = wa; a_wdata = wd; a_raddr = {r1, r0};
   endtask

   task automatic a_model_write();
      if (!a_reset && a_we && a_waddr != 5'd0) ma[a_waddr] = a_wdata;
   endtask

   task automatic b_model_write();
      if (!b_reset && b_we && b_waddr != 5'd0 && b_waddr < 5'd24) mb[b_waddr] = b_wdata;
   endtask

   initial begin
      int n;
      logic [4:0]  r0, r1, r2;
      logic [31:0] old31;

      vt[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd7,  5'd0,  32'h0,        32'h0};
      vt[1] = '{1'b1, 5'd0,  32'h12345678, 5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF};
      vt[2] = '{1'b1, 5'd9,  32'h00001111, 5'd0,  5'd5,  32'h0,        32'hDEADBEEF};
      vt[3] = '{1'b0, 5'd9,  32'h0,        5'd9,  5'd0,  32'h00001111, 32'h0};
      vt[4] = '{1'b1, 5'd5,  32'hCAFEF00D, 5'd9,  5'd31, 32'h00001111, 32'h0};
      vt[5] = '{1'b1, 5'd1,  32'h13579BDF, 5'd5,  5'd5,  32'hCAFEF00D, 32'hCAFEF00D};
      vt[6] = '{1'b0, 5'd1,  32'h0,        5'd1,  5'd9,  32'h13579BDF, 32'h00001111};
      vt[7] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0,        32'h0};

      a_reset = 1'b1; b_reset = 1'b1;
      a_drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd31);
      b_we = 1'b0; b_waddr = '0; b_wdata = '0; b_raddr = '0;

      // Reset held two cycles, outputs quiet
      tick();
      chk("a_reset_ready", 64'(a_ready), 64'h0);
      chk("a_reset_rdata", a_rdata, 64'h0);
      chk("a_reset_obs", 64'(a_obs), 64'h0);
      tick();
      a_reset = 1'b0;

      // First clear, with a dropped write to x7 presented at clear cycle 10
      for (int c = 1; c <= 32; c++) begin
         a_drive(c == 10, 5'd7, 32'hAAAA5555, 5'd7, 5'(c - 1));
         #1;
         chk("a_clear_ready_low", 64'(a_ready), 64'h0);
         chk("a_clear_rdata_zero", a_rdata, 64'h0);
         chk("a_clear_obs_zero", 64'(a_obs), 64'h0);
         tick();
      end
      a_drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
      chk("a_ready_after_32", 64'(a_ready), 64'h1);
      for (int i = 0; i < 32; i++) ma[i] = 32'h0;

      for (int i = 0; i < 32; i++) begin
         a_drive(1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
         #1;
         chk("a_post_clear_zero", a_rdata, 64'h0);
         tick();
      end

      for (int v = 0; v < 8; v++) begin
         a_drive(vt[v].we, vt[v].wa, vt[v].wd, vt[v].r0, vt[v].r1);
         #1;
         chk("a_vec_lane0", 64'(a_rdata[31:0]), 64'(vt[v].e0));
         chk("a_vec_lane1", 64'(a_rdata[63:32]), 64'(vt[v].e1));
         tick();
         a_model_write();
      end

      // Same-cycle read of the address being written, plus observe timing
      a_drive(1'b1, 5'd31, 32'h11112222, 5'd0, 5'd0);
      tick(); a_model_write();
      chk("a_obs_first", 64'(a_obs), 64'h11112222);
      old31 = 32'h11112222;
      a_drive(1'b1, 5'd31, 32'h0000CAFE, 5'd31, 5'd31);
      #1;
`ifdef REGFILE_WRITE_BYPASS_EN
      chk("a_same_cycle_l0", 64'(a_rdata[31:0]), 64'h0000CAFE);
      chk("a_same_cycle_l1", 64'(a_rdata[63:32]), 64'h0000CAFE);
`else
      chk("a_same_cycle_l0", 64'(a_rdata[31:0]), 64'(old31));
      chk("a_same_cycle_l1", 64'(a_rdata[63:32]), 64'(old31));
`endif
      chk("a_same_cycle_obs", 64'(a_obs), 64'(old31));
      tick(); a_model_write();
      a_drive(1'b1, 5'd0, 32'h12345678, 5'd31, 5'd0);
      #1;
      chk("a_next_cycle_read", 64'(a_rdata[31:0]), 64'h0000CAFE);
      chk("a_next_cycle_obs", 64'(a_obs), 64'h0000CAFE);
      chk("a_x0_write_read", 64'(a_rdata[63:32]), 64'h0);
      tick(); a_model_write();

      for (int k = 0; k < 400; k++) begin
         a_drive(1'($urandom), 5'($urandom), $urandom, 5'($urandom), 5'($urandom));
         if ($urandom_range(3) == 0) a_raddr[4:0] = a_waddr;
         #1;
         chk("a_rand_lane0", 64'(a_rdata[31:0]),
             64'(exp_a(a_raddr[4:0], a_we, a_waddr, a_wdata)));
         chk("a_rand_lane1", 64'(a_rdata[63:32]),
             64'(exp_a(a_raddr[9:5], a_we, a_waddr, a_wdata)));
         chk("a_rand_obs", 64'(a_obs), 64'(ma[31]));
         tick(); a_model_write();
      end

      // Reset in RUN with a write in the same cycle
      a_reset = 1'b1;
      a_drive(1'b1, 5'd3, 32'h00000077, 5'd3, 5'd31);
      tick();
      a_reset = 1'b0;
      a_we = 1'b0;
      chk("a_run_reset_ready", 64'(a_ready), 64'h0);
      chk("a_run_reset_rdata", a_rdata, 64'h0);
      wait_ready(0, n);
      chk("a_clear_len_after_run_reset", 64'(n), 64'd32);
      #1;
      chk("a_x3_after_clear", a_rdata, 64'h0);

      // Reset again mid-clear at cycle 20
      a_reset = 1'b1; tick(); a_reset = 1'b0;
      for (int c = 0; c < 20; c++) tick();
      chk("a_mid_clear_not_ready", 64'(a_ready), 64'h0);
      a_reset = 1'b1; tick(); a_reset = 1'b0;
      wait_ready(0, n);
      chk("a_clear_len_after_mid_reset", 64'(n), 64'd32);
      a_reset = 1'b1;

      // 24-register, 3-port, 64-bit instance
      tick();
      chk("b_reset_ready", 64'(b_ready), 64'h0);
      tick();
      b_reset = 1'b0;
      wait_ready(1, n);
      chk("b_clear_len", 64'(n), 64'd24);
      for (int i = 0; i < 24; i++) mb[i] = 64'h0;

      for (int i = 0; i < 32; i++) begin
         b_raddr = {5'(i + 16), 5'(i + 8), 5'(i)};
         #1;
         chk("b_post_clear_zero", b_rdata[63:0] | b_rdata[127:64] | b_rdata[191:128], 64'h0);
         tick();
      end

      b_we = 1'b1; b_waddr = 5'd27; b_wdata = 64'hFFFF_EEEE_DDDD_CCCC;
      b_raddr = {5'd27, 5'd27, 5'd27};
      tick(); b_model_write();
      b_we = 1'b0;
      b_raddr = {5'd27, 5'd11, 5'd3};
      #1;
      chk("b_read27_after_write27", b_rdata[191:128], 64'h0);
      chk("b_alias11_untouched", b_rdata[127:64], 64'h0);
      chk("b_alias3_untouched", b_rdata[63:0], 64'h0);

      b_we = 1'b1;
      b_waddr = 5'd1;  b_wdata = 64'h0123_4567_89AB_CDEF; tick(); b_model_write();
      b_waddr = 5'd12; b_wdata = 64'hFEDC_BA98_7654_3210; tick(); b_model_write();
      b_waddr = 5'd23; b_wdata = 64'h8000_0000_0000_0001; tick(); b_model_write();
      b_we = 1'b0;
      b_raddr = {5'd23, 5'd12, 5'd1};
      #1;
      chk("b_lane0_distinct", b_rdata[63:0], 64'h0123_4567_89AB_CDEF);
      chk("b_lane1_distinct", b_rdata[127:64], 64'hFEDC_BA98_7654_3210);
      chk("b_lane2_distinct", b_rdata[191:128], 64'h8000_0000_0000_0001);
      chk("b_obs_23", b_obs, 64'h8000_0000_0000_0001);
      tick();

      for (int k = 0; k < 300; k++) begin
         b_we = 1'($urandom); b_waddr = 5'($urandom); b_wdata = {$urandom, $urandom};
         r0 = 5'($urandom); r1 = 5'($urandom); r2 = 5'($urandom);
         if ($urandom_range(3) == 0) r1 = b_waddr;
         b_raddr = {r2, r1, r0};
         #1;
         chk("b_rand_lane0", b_rdata[63:0], exp_b(r0, b_we, b_waddr, b_wdata));
         chk("b_rand_lane1", b_rdata[127:64], exp_b(r1, b_we, b_waddr, b_wdata));
         chk("b_rand_lane2", b_rdata[191:128], exp_b(r2, b_we, b_waddr, b_wdata));
         chk("b_rand_obs", b_obs, mb[23]);
         tick(); b_model_write();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/register_file_multiport.md
# register_file_multiport

Parametrised multi-read-port integer register file for the JZJCoreF datapath, successor to the fixed 32×32, two-read-port file. Register 0 always reads zero. After reset it clears its storage one register per cycle, so it can be implemented in block RAM, and raises `ready` when the clear is finished. An optional same-cycle write-to-read bypass can be compiled in.

## Interface
- `XLEN`, default 32: register width in bits.
- `REG_COUNT`, default 32: number of architectural registers; must be ≥2.
- `READ_PORTS`, default 2: number of independent read ports; must be ≥1.
- `ADDR_WIDTH`, default `$clog2(REG_COUNT)`: width of each register address.
- `OBSERVE_INDEX`, default `REG_COUNT-1`: register continuously driven on `observeOutput`.

- `clock` input 1: the single clock; all state updates on its rising edge.
- `reset` input 1: synchronous, active-high.
- `readAddress` input `READ_PORTS*ADDR_WIDTH`: packed read addresses; port p uses bits `[p*ADDR_WIDTH +: ADDR_WIDTH]`.
- `readData` output `READ_PORTS*XLEN`: packed read data; port p uses bits `[p*XLEN +: XLEN]`.
- `writeAddress` input `ADDR_WIDTH`: destination register.
- `writeData` input `XLEN`: data to write.
- `writeEnable` input 1: commit `writeData` at the next rising edge.
- `ready` output 1: high once the post-reset clear is complete.
- `observeOutput` output `XLEN`: contents of register `OBSERVE_INDEX`, for debug and LEDs.

## Operation
- Two-state FSM with states CLEAR and RUN, plus a clear counter `clearIndex` of `ADDR_WIDTH` bits.
- Reset:
  - While `reset` is high at a rising edge: state becomes CLEAR, `clearIndex` becomes 0, `ready` becomes 0.
  - Storage contents are not otherwise touched.
- CLEAR state:
  - Each rising edge with `reset` low writes 0 to `reg[clearIndex]` and increments `clearIndex`.
  - When `clearIndex == REG_COUNT-1` at the edge, that register is cleared and state moves to RUN with `ready` = 1.
  - All `readData` lanes and `observeOutput` are forced to 0.
  - `writeEnable` is ignored; writes issued during CLEAR are dropped, not queued.
- RUN state:
  - Reads are combinational: `readData[p] = reg[readAddress[p]]`.
  - Any lane addressing 0 returns 0.
  - A lane addressing ≥ `REG_COUNT` (possible only when `REG_COUNT` is not a power of two) returns 0.
  - Write: `writeEnable` with `writeAddress` ≠ 0 and < `REG_COUNT` stores `writeData` at the edge.
  - A write to address 0 or to an out-of-range address is discarded.
- Reset mid-clear: the clear restarts from index 0, and `ready` stays low for a full `REG_COUNT` further cycles after `reset` falls.
- Reset while in RUN: return to CLEAR and drop `ready`. A write presented in the same cycle as `reset` is discarded.
- Multiple read lanes may address the same register; each returns identical data.

## Timing
- Reset values: `ready` = 0, `readData` = 0, `observeOutput` = 0. These outputs hold these values until the clear completes.
- Clear latency: `ready` rises exactly `REG_COUNT` rising edges after the first edge sampling `reset` low (32 edges at default parameters).
- Read latency is 0 cycles: `readData` follows `readAddress` combinationally.
- Write latency is 1 cycle: data written at edge N is visible on reads during cycle N+1.
- Without bypass, a same-cycle read of the address being written returns the old value.
- `observeOutput` reflects a write to `OBSERVE_INDEX` from the cycle after that write's edge. The bypass does not apply to it.

## Configuration
- Macro: `REGFILE_WRITE_BYPASS_EN`.
- Defined: in RUN, any read lane whose address equals `writeAddress` while `writeEnable` = 1 returns `writeData` combinationally in the same cycle.
  - Addresses 0 and out-of-range addresses are never bypassed and still return 0.
  - Bypass is inactive in CLEAR.
- Undefined: no forwarding path; behaviour is exactly as described in Timing.

## Test plan
- Reset then clear:
  - Stimulus: hold `reset` 2 cycles, then release.
  - Response: `ready` = 0 for 32 edges, then 1. All read lanes read 0 for every address.
- Write then read:
  - Stimulus: write 0xDEADBEEF to x5; read x5 on both ports the next cycle.
  - Response: 0xDEADBEEF on both lanes.
  - Stimulus: write 0x12345678 to x0.
  - Response: x0 still reads 0.
- Writes during CLEAR are dropped:
  - Stimulus: assert `writeEnable` with x7 = 0xAAAA5555 during cycle 10 of the clear.
  - Response: after `ready`, x7 reads 0.
- Reset mid-clear:
  - Stimulus: reassert `reset` at clear cycle 20, then release.
  - Response: `ready` rises 32 edges after the release, not 12.
- Same-cycle read of the write address:
  - Stimulus: write 0x0000CAFE to x31 while reading x31.
  - Response with `REGFILE_WRITE_BYPASS_EN`: `readData` = 0x0000CAFE in the same cycle.
  - Response without it: the old value that cycle, 0x0000CAFE the next.
  - In both builds, `observeOutput` shows 0x0000CAFE from the next cycle.
- Non-default parameters:
  - Stimulus: `REG_COUNT` = 24, `READ_PORTS` = 3, `XLEN` = 64.
  - Response: the clear takes 24 cycles. A read of address 27 returns 0, and a write to address 27 is dropped. Three lanes read distinct 64-bit values correctly.
